// File: rtl/bias_addr_gen_v2.sv
// bias_addr_gen_v2
//   Generates bias-buffer read addresses, one per PE output event, for a job
//   of part_num parts x out_piece pieces. A job is started by a pulse on
//   calculate_enble while idle. Each pe_out_en in RUN produces one registered
//   read strobe with its address and part/piece indices.
//
// Ports
//   clk, rst         : clock, synchronous active-high reset
//   calculate_enble  : job start pulse (ignored while busy)
//   part_num         : number of parts in the job
//   out_piece        : pieces per part
//   addr_start_b     : base bias address
//   addr_stride      : address increment per read (0 = broadcast)
//   mode             : 0 = restart at base each part, 1 = continuous
//   pe_out_en        : request for one bias read
//   o_b_addr         : bias read address (held between strobes)
//   o_rd_en          : read strobe, one cycle per read
//   o_part_idx       : part index of the current read
//   o_piece_idx      : piece index of the current read
//   o_part_end       : marks the last read of each part
//   o_done           : marks the last read of the job, or a zero-count job
//   o_busy           : high while a job is active
module bias_addr_gen_v2 #(
    parameter int ADDR_W  = 8,
    parameter int PART_W  = 5,
    parameter int PIECE_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               calculate_enble,
    input  logic [PART_W-1:0]  part_num,
    input  logic [PIECE_W-1:0] out_piece,
    input  logic [ADDR_W-1:0]  addr_start_b,
    input  logic [ADDR_W-1:0]  addr_stride,
    input  logic               mode,
    input  logic               pe_out_en,
    output logic [ADDR_W-1:0]  o_b_addr,
    output logic               o_rd_en,
    output logic [PART_W-1:0]  o_part_idx,
    output logic [PIECE_W-1:0] o_piece_idx,
    output logic               o_part_end,
    output logic               o_done,
    output logic               o_busy
);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t             state;

    // Job registers, captured on an accepted start
    logic [PART_W-1:0]  part_num_r;
    logic [PIECE_W-1:0] out_piece_r;
    logic [ADDR_W-1:0]  base_r;
    logic [ADDR_W-1:0]  stride_r;
    logic               mode_r;

    logic [PART_W-1:0]  part_cnt;
    logic [PIECE_W-1:0] piece_cnt;
    logic [ADDR_W-1:0]  addr_acc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            part_num_r  <= '0;
            out_piece_r <= '0;
            base_r      <= '0;
            stride_r    <= '0;
            mode_r      <= 1'b0;
            part_cnt    <= '0;
            piece_cnt   <= '0;
            addr_acc    <= '0;
            o_b_addr    <= '0;
            o_rd_en     <= 1'b0;
            o_part_idx  <= '0;
            o_piece_idx <= '0;
            o_part_end  <= 1'b0;
            o_done      <= 1'b0;
            o_busy      <= 1'b0;
        end else begin
            // Strobes are single-cycle pulses
            o_rd_en    <= 1'b0;
            o_part_end <= 1'b0;
            o_done     <= 1'b0;

            case (state)
                IDLE: begin
                    if (calculate_enble) begin
                        part_num_r  <= part_num;
                        out_piece_r <= out_piece;
                        base_r      <= addr_start_b;
                        stride_r    <= addr_stride;
                        mode_r      <= mode;
                        part_cnt    <= '0;
                        piece_cnt   <= '0;
                        addr_acc    <= addr_start_b;
                        // Zero-count job completes at once without any read
                        if (part_num == '0 || out_piece == '0) begin
                            o_done <= 1'b1;
                        end else begin
                            state  <= RUN;
                            o_busy <= 1'b1;
                        end
                    end
                end

                RUN: begin
                    if (pe_out_en) begin
                        o_b_addr    <= addr_acc;
                        o_rd_en     <= 1'b1;
                        o_part_idx  <= part_cnt;
                        o_piece_idx <= piece_cnt;
                        if (piece_cnt != out_piece_r - PIECE_W'(1)) begin
                            piece_cnt <= piece_cnt + PIECE_W'(1);
                            addr_acc  <= addr_acc + stride_r;
                        end else begin
                            o_part_end <= 1'b1;
                            piece_cnt  <= '0;
                            addr_acc   <= mode_r ? (addr_acc + stride_r) : base_r;
                            if (part_cnt != part_num_r - PART_W'(1)) begin
                                part_cnt <= part_cnt + PART_W'(1);
                            end else begin
                                // busy drops together with done, so a start
                                // in the done cycle is accepted back-to-back
                                o_done <= 1'b1;
                                o_busy <= 1'b0;
                                state  <= IDLE;
                            end
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/bias_addr_gen_v2.md
# bias_addr_gen_v2

Parametrised successor to the bias address generator: produces bias-buffer read addresses, one per PE output event, for a job of `part_num` parts × `out_piece` pieces. Sits between the scheduler/decoder and the bias buffer and is paced by the weight-AGU's `pe_out_en`. It adds the following over the previous generation:
- configurable widths;
- programmable address stride, including 0 for broadcast;
- a per-part or continuous addressing mode;
- busy/done status;
- defined zero-count and wrap behaviour.

## Interface
Parameters:
- `ADDR_W`, 8, bias-buffer address width.
- `PART_W`, 5, width of part count and part index.
- `PIECE_W`, 8, width of piece count and piece index.

Ports:
- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `calculate_enble`  in  1  job start pulse, from the scheduler.
- `part_num`  in  PART_W  number of parts, from the decoder.
- `out_piece`  in  PIECE_W  pieces per part, from the decoder.
- `addr_start_b`  in  ADDR_W  base bias address.
- `addr_stride`  in  ADDR_W  address increment per read.
- `mode`  in  1  addressing mode: 0 = per-part restart, 1 = continuous.
- `pe_out_en`  in  1  one PE output ready; requests one bias read.
- `o_b_addr`  out  ADDR_W  bias read address.
- `o_rd_en`  out  1  bias read strobe, 1-cycle pulse.
- `o_part_idx`  out  PART_W  part index of the current read.
- `o_piece_idx`  out  PIECE_W  piece index of the current read.
- `o_part_end`  out  1  pulses with the last read of each part.
- `o_done`  out  1  pulses with the last read of the job, or on a zero-count job.
- `o_busy`  out  1  high while a job is active.

## Operation
FSM states: IDLE and RUN. `o_busy` = (state == RUN).

IDLE:
- `calculate_enble`=1 latches `part_num`, `out_piece`, `addr_start_b`, `addr_stride` and `mode` into job registers.
- It clears `piece_cnt`, `part_cnt` and loads `addr_acc` = `addr_start_b`.
- If `part_num`==0 or `out_piece`==0: stay IDLE, pulse `o_done` for 1 cycle, never assert `o_rd_en`.
- Otherwise: go to RUN.
- `pe_out_en` in IDLE is ignored.

RUN, for each sampled `pe_out_en`=1:
- Register outputs: `o_b_addr` = `addr_acc`, `o_rd_en`=1, `o_part_idx` = `part_cnt`, `o_piece_idx` = `piece_cnt`.
- If `piece_cnt` ≠ `out_piece`−1: `piece_cnt`++ and `addr_acc` += stride.
- Otherwise (last piece of the part):
  - `o_part_end`=1 and `piece_cnt`=0.
  - mode 0: `addr_acc` = base. mode 1: `addr_acc` += stride.
  - If `part_cnt` ≠ `part_num`−1: `part_cnt`++.
  - Else: `o_done`=1 and the FSM returns to IDLE.

Also in RUN:
- `calculate_enble` while in RUN is ignored. Job registers are not reloaded.
- Decoder inputs may change freely after the start cycle without effect.

Arithmetic:
- Address addition is modulo 2^ADDR_W and wraps silently.
- Resulting sequence: mode 1 read n is at base + n·stride; mode 0 read is at base + piece·stride.
- Stride 0 gives the same address for every read.

Reset:
- `rst`=1 has priority over every other input, including mid-job.
- State → IDLE; counters and `addr_acc` → 0.
- All outputs → 0: `o_b_addr`, `o_rd_en`, `o_part_idx`, `o_piece_idx`, `o_part_end`, `o_done`, `o_busy`.
- A job interrupted by reset is abandoned; no `o_done` is issued for it.

## Timing
- All outputs are registered.
- `o_b_addr`, `o_part_idx` and `o_piece_idx` hold their last values between strobes.
- Start accepted at edge t: `o_busy`=1 from cycle t+1. `pe_out_en` in the same cycle as the accepted start is ignored.
- `pe_out_en` sampled high at edge k: `o_rd_en`, address and indices are valid in cycle k+1. Latency is 1.
- `pe_out_en` may be high every cycle: one read per cycle, no stalls, no backpressure.
- `o_part_end` and `o_done` are coincident with the `o_rd_en` of the corresponding read.
- On the final read, `o_busy` falls in the same cycle that `o_done`=1.
- A new `calculate_enble` in that same cycle is accepted, giving back-to-back jobs with zero gap.
- Zero-count job: start at edge t gives `o_done`=1 in cycle t+1, with `o_busy` remaining 0.

## Test plan
- Mode 0 baseline: `part_num`=3, `out_piece`=3, base=0, stride=1, `pe_out_en` 1 cycle every 3 → `o_b_addr` 0,1,2,0,1,2,0,1,2. `o_part_end` on reads 3, 6, 9. `o_done` on read 9 only. `o_busy` drops with read 9.
- Mode 1 continuous: same config, base=16, stride=2, `pe_out_en` every cycle → addresses 16,18,…,32 on 9 consecutive cycles. `o_part_idx` 0,0,0,1,1,1,2,2,2.
- Wrap and broadcast:
  - ADDR_W=8, mode 1, base=254, stride=1, 1×4 job → 254,255,0,1.
  - Stride=0, 2×2 job → all four addresses equal base.
- Zero count and ignored inputs:
  - `part_num`=0 → `o_done` 1 cycle after start, no `o_rd_en`, `o_busy` stays 0.
  - `pe_out_en` in IDLE → no `o_rd_en`.
  - Start mid-job → job unchanged.
- Reset and back-to-back:
  - `rst` after read 4 of a 3×3 job → all outputs 0 next cycle; a new 1×2 job then gives base, base+stride.
  - Start in the `o_done` cycle → second job's first read one cycle after the next `pe_out_en`.
